// File: rtl/laser_pkg.sv
// Shared types, default sizing and the squared-distance helper for the LASER
// point-store / coverage-scoring stage.
package laser_pkg;

  localparam int NPTS  = 40;
  localparam int LANES = 4;
  localparam int R2    = 16;

  typedef logic [3:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef logic [8:0] dist2_t;
  typedef logic [5:0] count_t;

  typedef enum logic [1:0] {
    LOAD,
    IDLE,
    SCAN,
    DONE_ST
  } state_t;

  // Differences are taken as signed 5-bit values so 0 and 15 are 15 apart,
  // never 1 (no wrap-around on the 4-bit grid).
  function automatic dist2_t dist2(point_t a, point_t b);
    logic signed [4:0] dx, dy, ndx, ndy;
    logic [3:0] ax, ay;
    logic [7:0] sx, sy;
    dx  = $signed({1'b0, a.x}) - $signed({1'b0, b.x});
    dy  = $signed({1'b0, a.y}) - $signed({1'b0, b.y});
    ndx = -dx;
    ndy = -dy;
    ax  = dx[4] ? ndx[3:0] : dx[3:0];
    ay  = dy[4] ? ndy[3:0] : dy[3:0];
    sx  = 8'(ax) * 8'(ax);
    sy  = 8'(ay) * 8'(ay);
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_dist_chk.sv
// One scoring lane: a point counts when it lies within the coverage radius of
// the candidate centre and is not already inside the optional exclusion disc.
module laser_dist_chk
  import laser_pkg::*;
#(
  parameter int R2 = laser_pkg::R2
) (
  input  point_t centre,
  input  point_t excl,
  input  logic   ex_en,
  input  point_t pt,
  output logic   hit
);

  dist2_t d_centre;
  dist2_t d_excl;

  assign d_centre = dist2(centre, pt);
  assign d_excl   = dist2(excl, pt);

  assign hit = (d_centre <= dist2_t'(R2)) && !(ex_en && (d_excl <= dist2_t'(R2)));

endmodule

// File: rtl/laser_cover_eval.sv
// Point store and coverage scorer: captures NPTS points, then answers each
// centre query with the covered-and-not-excluded point count, LANES per cycle.
module laser_cover_eval
  import laser_pkg::*;
#(
  parameter int NPTS  = laser_pkg::NPTS,
  parameter int LANES = laser_pkg::LANES,
  parameter int R2    = laser_pkg::R2
) (
  input  logic       clk,
  input  logic       rst,        // active-low asynchronous
  input  logic       in_valid,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       reload,
  output logic       loaded,
  input  logic       q_valid,
  output logic       q_ready,
  input  logic [3:0] qx,
  input  logic [3:0] qy,
  input  logic       ex_en,
  input  logic [3:0] exx,
  input  logic [3:0] exy,
  output logic       res_valid,
  output logic [5:0] res_count
);

  localparam int     SUM_W     = $clog2(LANES + 1);
  localparam count_t LAST_PT   = count_t'(NPTS - 1);
  localparam count_t LAST_BASE = count_t'(NPTS - LANES);

  state_t             state;
  count_t             cnt;
  count_t             base;
  count_t             acc;
  point_t             pts [NPTS];
  point_t             q_centre;
  point_t             q_excl;
  logic               q_ex_en;
  logic [LANES-1:0]   hits;
  logic [SUM_W-1:0]   hit_sum;
  logic               store;
  logic               accept;

  // RELOAD wins over both a point write and a query accept in the same cycle.
  assign store  = (state == LOAD) && in_valid && !reload;
  assign accept = q_valid && q_ready && !reload;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    point_t lane_pt;
    assign lane_pt = pts[base + count_t'(g)];

    laser_dist_chk #(.R2(R2)) u_chk (
      .centre (q_centre),
      .excl   (q_excl),
      .ex_en  (q_ex_en),
      .pt     (lane_pt),
      .hit    (hits[g])
    );
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      hit_sum = hit_sum + SUM_W'(hits[i]);
    end
  end

  // NOTE: the point array is plain storage with no reset; it is always fully
  // rewritten before any query can be accepted, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (store) pts[cnt] <= {x, y};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      base      <= '0;
      acc       <= '0;
      loaded    <= 1'b0;
      q_ready   <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      q_centre  <= '0;
      q_excl    <= '0;
      q_ex_en   <= 1'b0;
    end else if (reload) begin
      state     <= LOAD;
      cnt       <= '0;
      loaded    <= 1'b0;
      q_ready   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (store) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_PT) begin
              state   <= IDLE;
              loaded  <= 1'b1;
              q_ready <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (accept) begin
            q_centre  <= {qx, qy};
            q_excl    <= {exx, exy};
            q_ex_en   <= ex_en;
            res_valid <= 1'b0;
            acc       <= '0;
            base      <= '0;
            q_ready   <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          acc  <= acc + count_t'(hit_sum);
          base <= base + count_t'(LANES);
          if (base == LAST_BASE) state <= DONE_ST;
        end
        DONE_ST: begin
          res_count <= acc;
          res_valid <= 1'b1;
          q_ready   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_cover_eval.sv
// Directed and randomized checks of laser_cover_eval against a counting model
// evaluated directly from the coverage rules on a plain array of points.
module tb_laser_cover_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] x, y;
  logic       reload;
  logic       loaded;
  logic       q_valid;
  logic       q_ready;
  logic [3:0] qx, qy;
  logic       ex_en;
  logic [3:0] exx, exy;
  logic       res_valid;
  logic [5:0] res_count;

  int compared   = 0;
  int mismatched = 0;
  int mx [40];
  int my [40];

  always #5 clk = ~clk;

  laser_cover_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .reload    (reload),
    .loaded    (loaded),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .qx        (qx),
    .qy        (qy),
    .ex_en     (ex_en),
    .exx       (exx),
    .exy       (exy),
    .res_valid (res_valid),
    .res_count (res_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(int cx, int cy, int en, int ex, int ey);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      int d, de;
      d  = (cx - mx[i]) * (cx - mx[i]) + (cy - my[i]) * (cy - my[i]);
      de = (ex - mx[i]) * (ex - mx[i]) + (ey - my[i]) * (ey - my[i]);
      if (d <= 16 && !(en != 0 && de <= 16)) n++;
    end
    return n;
  endfunction

  task automatic fill(input int px, input int py, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      mx[i] = px;
      my[i] = py;
    end
  endtask

  task automatic load_img(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 39) begin
        check({tag, "_loaded_before_last"}, loaded, 0);
        check({tag, "_qready_in_load"}, q_ready, 0);
      end
      in_valid = 1'b1;
      x = 4'(mx[i]);
      y = 4'(my[i]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_loaded"}, loaded, 1);
    check({tag, "_qready_idle"}, q_ready, 1);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_loaded", loaded, 0);
  endtask

  // Returns at the falling edge right after the accept edge.
  task automatic start_query(input int cx, input int cy, input int en, input int ex, input int ey,
                             input string tag);
    int n = 0;
    @(negedge clk);
    while (q_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_ready_timeout"}, q_ready, 1);
    q_valid = 1'b1;
    qx = 4'(cx); qy = 4'(cy); ex_en = en[0]; exx = 4'(ex); exy = 4'(ey);
    @(negedge clk);
    q_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp, input string tag);
    int lat = 0;
    check({tag, "_valid_cleared"}, res_valid, 0);
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 11);
    check({tag, "_count"}, res_count, exp);
  endtask

  task automatic query(input int cx, input int cy, input int en, input int ex, input int ey,
                       input string tag);
    start_query(cx, cy, en, ex, ey, tag);
    wait_result(ref_count(cx, cy, en, ex, ey), tag);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; x = '0; y = '0; reload = 1'b0;
    q_valid = 1'b0; qx = '0; qy = '0; ex_en = 1'b0; exx = '0; exy = '0;
    #12;
    check("rst_loaded", loaded, 0);
    check("rst_qready", q_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_count", res_count, 0);
    @(negedge clk);
    rst = 1'b1;

    // All points at (8,8): radius boundary cases.
    fill(8, 8, 0, 39);
    load_img("img88");
    query(8, 8, 0, 0, 0, "q88");
    query(12, 8, 0, 0, 0, "q128_d16");
    query(13, 8, 0, 0, 0, "q138_d25");
    query(11, 11, 0, 0, 0, "q1111_d18");

    // Points offered outside LOAD must not disturb the stored image.
    @(negedge clk);
    in_valid = 1'b1; x = 4'd0; y = 4'd0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    query(0, 0, 0, 0, 0, "idle_points_ignored");
    query(8, 8, 0, 0, 0, "q88_again");

    // Two clusters with exclusion.
    do_reload();
    fill(2, 2, 0, 19);
    fill(12, 12, 20, 39);
    load_img("img2clus");
    query(2, 2, 1, 2, 2, "excl_self");
    query(12, 12, 1, 2, 2, "excl_other");
    query(2, 2, 0, 2, 2, "excl_off");

    // Corner points: no wrap-around.
    do_reload();
    fill(0, 15, 0, 39);
    load_img("imgcorner");
    query(0, 11, 0, 0, 0, "corner_d16");
    query(15, 0, 0, 0, 0, "corner_far");

    // Randomized images clustered around a random spot.
    for (int it = 0; it < 3; it++) begin
      int cx, cy;
      do_reload();
      cx = $urandom_range(0, 15);
      cy = $urandom_range(0, 15);
      for (int i = 0; i < 40; i++) begin
        int px, py;
        px = cx + $urandom_range(0, 8) - 4;
        py = cy + $urandom_range(0, 8) - 4;
        mx[i] = (px < 0) ? 0 : (px > 15) ? 15 : px;
        my[i] = (py < 0) ? 0 : (py > 15) ? 15 : py;
      end
      load_img("imgrand");
      for (int k = 0; k < 5; k++) begin
        query($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 15), "rand");
      end
      query(cx, cy, 0, 0, 0, "rand_centre");
    end

    // RELOAD on the 5th SCAN cycle aborts the query.
    start_query(5, 5, 0, 0, 0, "abort");
    repeat (4) @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("abort_loaded", loaded, 0);
    check("abort_qready", q_ready, 0);
    check("abort_res_valid", res_valid, 0);
    repeat (15) @(negedge clk);
    check("abort_no_result", res_valid, 0);

    // RELOAD alongside a point discards it; Q_VALID held through LOAD.
    @(negedge clk);
    in_valid = 1'b1; x = 4'd15; y = 4'd15; reload = 1'b1;
    @(negedge clk);
    reload = 1'b0; in_valid = 1'b0;
    q_valid = 1'b1; qx = 4'd3; qy = 4'd3; ex_en = 1'b0; exx = '0; exy = '0;
    fill(3, 3, 0, 39);
    load_img("img33");
    @(negedge clk);
    q_valid = 1'b0;
    wait_result(ref_count(3, 3, 0, 0, 0), "held_query");
    query(15, 15, 0, 0, 0, "reload_point_dropped");

    // RELOAD in the accept cycle drops the query.
    @(negedge clk);
    while (q_ready !== 1'b1) @(negedge clk);
    q_valid = 1'b1; qx = 4'd3; qy = 4'd3; reload = 1'b1;
    @(negedge clk);
    q_valid = 1'b0; reload = 1'b0;
    check("reload_accept_qready", q_ready, 0);
    check("reload_accept_loaded", loaded, 0);
    repeat (14) @(negedge clk);
    check("reload_accept_dropped", res_valid, 0);
    load_img("img33b");
    query(3, 3, 0, 0, 0, "q33");

    // Asynchronous reset mid-SCAN.
    start_query(3, 3, 0, 0, 0, "async");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_loaded", loaded, 0);
    check("arst_qready", q_ready, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_count", res_count, 0);
    @(negedge clk);
    rst = 1'b1;
    fill(9, 4, 0, 39);
    load_img("imgpost");
    query(9, 8, 0, 0, 0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/laser_cover_eval.md
Name: laser_cover_eval

Overview:
- Point-store and coverage-scoring stage that sits between the image pixel stream and the LASER centre-search FSM.
- Captures the 40 (X,Y) target points streamed after reset or reload into a register array.
- Answers centre-candidate queries with the number of points within radius 4 of the candidate; points already covered by an optional exclusion centre are not counted.
- The search FSM issues queries and keeps the best pair; this block does all distance arithmetic.

Parameters:
- NPTS, 40, number of points captured per image.
- LANES, 4, points evaluated per scan cycle; must divide NPTS.
- R2, 16, squared coverage radius; a point is covered when distance squared <= R2.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, active-low asynchronous assert, synchronous release by the parent.
- IN_VALID  in  1  X/Y carry a point this cycle.
- X  in  4  point column.
- Y  in  4  point row.
- RELOAD  in  1  one-cycle pulse; discard stored points and re-enter capture.
- LOADED  out  1  all NPTS points captured.
- Q_VALID  in  1  query request.
- Q_READY  out  1  block can accept a query.
- QX  in  4  candidate centre column.
- QY  in  4  candidate centre row.
- EX_EN  in  1  apply exclusion centre.
- EXX  in  4  exclusion centre column.
- EXY  in  4  exclusion centre row.
- RES_VALID  out  1  RES_COUNT holds the result of the last accepted query.
- RES_COUNT  out  6  covered-and-not-excluded point count, 0..NPTS.

Behaviour:
- Reset (RST=0): state LOAD, point count 0, LOADED=0, Q_READY=0, RES_VALID=0, RES_COUNT=0. Stored point array is not cleared.
- LOAD state:
  - Each cycle with IN_VALID=1 stores {X,Y} at index cnt and increments cnt.
  - After the NPTS-th point: LOADED=1 next cycle, go to IDLE.
  - Q_READY=0 throughout.
- IDLE state:
  - Q_READY=1.
  - A query is accepted on Q_VALID&&Q_READY; QX, QY, EX_EN, EXX, EXY are latched that cycle.
  - On accept: RES_VALID clears next cycle, go to SCAN.
- SCAN state:
  - Q_READY=0.
  - Each cycle evaluates LANES points, indices base..base+LANES-1, and adds their hits to an accumulator.
  - After NPTS/LANES cycles: go to DONE_ST.
- DONE_ST state:
  - RES_COUNT=acc and RES_VALID=1 are registered; go to IDLE.
  - Latency from accept edge to RES_VALID high: NPTS/LANES+1 cycles (11 at defaults).
  - RES_VALID and RES_COUNT hold until the next accept or RELOAD.
- Arithmetic:
  - dx = signed 5-bit (QX−PX); dx² is 8 bits (max 225); same for dy.
  - Distance squared d = dx²+dy², 9 bits (max 450).
  - hit = (d <= R2) && !(EX_EN && dEx <= R2), where dEx uses EXX/EXY.
  - Per-cycle hit sum is 3 bits; accumulator is 6 bits and never exceeds NPTS.
- IN_VALID outside LOAD: ignored. Extra points beyond NPTS: ignored.
- RELOAD in any state, including mid-SCAN:
  - Next cycle: LOAD, cnt=0, LOADED=0, RES_VALID=0, scan aborted.
  - RELOAD in the same cycle as an IN_VALID point: the point is discarded, not stored as index 0.
  - RELOAD in the same cycle as a query accept: RELOAD wins and the query is dropped.
- Q_VALID while Q_READY=0: not accepted; requester must hold Q_VALID.
- Coordinates 0 and 15 are legal; no wrap-around. Differences are signed, so |0−15|=15 and 225 > R2.

Decomposition:
- Package laser_pkg: coord_t (4-bit), point_t {x,y}, dist2_t (9-bit), count_t (6-bit), NPTS, R2, state enum {LOAD, IDLE, SCAN, DONE_ST}.
- Sub-module laser_dist_chk, combinational: inputs centre, exclusion centre, EX_EN, point; output hit. Instantiated LANES times.

Test Plan:
- Reset, stream 40 points all at (8,8), query (8,8) EX_EN=0 -> LOADED=1 after the 40th point; RES_VALID 11 cycles after accept; RES_COUNT=40.
- Same image, query (12,8) -> 40 (d=16, boundary inclusive); query (13,8) -> 0 (d=25); query (11,11) -> 0 (d=18).
- 20 points at (2,2) and 20 at (12,12); query (2,2) with EX_EN=1 at (2,2) -> 0; query (12,12) with EX_EN=1 at (2,2) -> 20; query (2,2) with EX_EN=0 -> 20.
- Corner points: 40 points at (0,15); query (0,11) -> 40; query (15,0) -> 0 (no wrap-around).
- Assert RELOAD on the 5th SCAN cycle -> RES_VALID stays 0, LOADED=0 next cycle, Q_READY=0; stream new 40 points at (3,3); query (3,3) -> 40.
- Hold Q_VALID through LOAD -> no accept until IDLE; assert RST low mid-SCAN -> all outputs reach reset values asynchronously.
